memory_pipe_responder: RTL and testbench

//  Memory-side endpoint of the core memory pipe: an on-chip SRAM responder that accepts requests from the arbiter.

---
 rtl/memory_pipe_responder_if.sv | 27 ++
 rtl/memory_pipe_responder.sv | 102 ++++++++++
 tb/tb_memory_pipe_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_pipe_responder_if.sv
// Request/response bundle between the core-side arbiter (master) and the SRAM responder (slave).
// Request: REQ/RW/ADDR/DATA/MASK/ORDER in, LOCK back. Response: VALID/DATA out, BUSY back.
// Handshake: a request is taken on REQ && !LOCK; a response is taken on VALID && !BUSY.
interface memory_pipe_responder_if;
  logic        iMEMORY_REQ;
  logic        oMEMORY_LOCK;
  logic [1:0]  iMEMORY_ORDER;
  logic [3:0]  iMEMORY_MASK;
  logic        iMEMORY_RW;
  logic [31:0] iMEMORY_ADDR;
  logic [31:0] iMEMORY_DATA;
  logic        oMEMORY_VALID;
  logic        iMEMORY_BUSY;
  logic [63:0] oMEMORY_DATA;

  modport master (
    output iMEMORY_REQ, iMEMORY_ORDER, iMEMORY_MASK, iMEMORY_RW,
           iMEMORY_ADDR, iMEMORY_DATA, iMEMORY_BUSY,
    input  oMEMORY_LOCK, oMEMORY_VALID, oMEMORY_DATA
  );

  modport slave (
    input  iMEMORY_REQ, iMEMORY_ORDER, iMEMORY_MASK, iMEMORY_RW,
           iMEMORY_ADDR, iMEMORY_DATA, iMEMORY_BUSY,
    output oMEMORY_LOCK, oMEMORY_VALID, oMEMORY_DATA
  );
endinterface

// File: rtl/memory_pipe_responder.sv
// On-chip SRAM responder: byte-masked 32-bit writes, 64-bit (two-word) reads queued in order.
// Latency: read accepted in cycle T is at the FIFO head in T+1 when the FIFO was empty.
// Backpressure: oMEMORY_LOCK = FIFO full, from registered count only; response held while iMEMORY_BUSY.
// Ports: iCLOCK, iRESET (async, active-high), iRESET_SYNC (sync flush), mem_if (slave side of the bundle).
module memory_pipe_responder #(
  parameter int ADDR_N      = 10,
  parameter int RSP_DEPTH   = 4,
  parameter int RSP_DEPTH_N = 2
) (
  input  logic                    iCLOCK,
  input  logic                    iRESET,
  input  logic                    iRESET_SYNC,
  memory_pipe_responder_if.slave  mem_if
);

  localparam int WORDS = 2 ** ADDR_N;
  localparam logic [RSP_DEPTH_N:0] FULL_CNT = (RSP_DEPTH_N + 1)'(RSP_DEPTH);

  logic [31:0]            mem_q  [WORDS];
  logic [63:0]            fifo_q [RSP_DEPTH];
  logic [RSP_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
  logic [RSP_DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
  logic [RSP_DEPTH_N:0]   count_q, count_d;
  logic [63:0]            last_q, last_d;

  logic [ADDR_N-1:0] word_idx;
  logic [ADDR_N-1:0] word_nxt;
  logic              full, empty, accept, push, pop;

  // Low byte-offset bits, high alias bits and the access size carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{mem_if.iMEMORY_ORDER, mem_if.iMEMORY_ADDR[31:ADDR_N+2],
                         mem_if.iMEMORY_ADDR[1:0]};

  assign word_idx = mem_if.iMEMORY_ADDR[ADDR_N+1:2];
  assign word_nxt = word_idx + 1'b1;  // wraps at the top of the array

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign accept = mem_if.iMEMORY_REQ && !full;
  assign push   = accept && !mem_if.iMEMORY_RW;
  assign pop    = !empty && !mem_if.iMEMORY_BUSY;

  assign mem_if.oMEMORY_LOCK  = full;
  assign mem_if.oMEMORY_VALID = !empty;
  // With nothing queued, keep presenting the last value handed over (0 after reset).
  assign mem_if.oMEMORY_DATA  = empty ? last_q : fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = fifo_q[rd_ptr_q];
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (iRESET_SYNC) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      last_d   = '0;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Storage is never cleared by either reset; only the queue bookkeeping is.
  always_ff @(posedge iCLOCK) begin
    if (accept && mem_if.iMEMORY_RW && !iRESET) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_if.iMEMORY_MASK[i]) begin
          mem_q[word_idx][8*i +: 8] <= mem_if.iMEMORY_DATA[8*i +: 8];
        end
      end
    end
    if (push && !iRESET && !iRESET_SYNC) begin
      fifo_q[wr_ptr_q] <= {mem_q[word_idx], mem_q[word_nxt]};
    end
  end

endmodule

// File: tb/tb_memory_pipe_responder.sv
module tb_memory_pipe_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic srst = 1'b0;
  always #5 clk = ~clk;

  memory_pipe_responder_if mif();

  memory_pipe_responder #(
    .ADDR_N(10), .RSP_DEPTH(4), .RSP_DEPTH_N(2)
  ) dut (
    .iCLOCK      (clk),
    .iRESET      (rst),
    .iRESET_SYNC (srst),
    .mem_if      (mif.slave)
  );

  typedef struct {
    logic        req;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  mask;
    logic        busy;
    logic        srst;
    logic        exp_v;
    logic        exp_l;
    logic [63:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  // Reference model: word array plus an ordered queue of pending responses.
  logic [31:0] mdl_mem [1024];
  logic [63:0] mq[$];
  logic [63:0] last_pop = '0;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic req, input logic rw, input logic [31:0] addr,
                     input logic [31:0] wdat, input logic [3:0] mask, input logic busy,
                     input logic sr, input logic ev, input logic el, input logic [63:0] ed);
    vec_t v;
    v.req = req; v.rw = rw; v.addr = addr; v.wdat = wdat; v.mask = mask;
    v.busy = busy; v.srst = sr; v.exp_v = ev; v.exp_l = el; v.exp_d = ed;
    vecs.push_back(v);
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance the model at the edge.
  task automatic step(input vec_t v, input string tag, input bit use_tbl, input bit use_mdl);
    logic [9:0]  w, wn;
    logic        lock_b;
    logic [63:0] md;
    mif.iMEMORY_REQ   = v.req;
    mif.iMEMORY_RW    = v.rw;
    mif.iMEMORY_ADDR  = v.addr;
    mif.iMEMORY_DATA  = v.wdat;
    mif.iMEMORY_MASK  = v.mask;
    mif.iMEMORY_ORDER = 2'($urandom_range(0, 2));
    mif.iMEMORY_BUSY  = v.busy;
    srst              = v.srst;
    @(negedge clk);
    md = (mq.size() != 0) ? mq[0] : last_pop;
    if (use_tbl) begin
      chk({tag, "_vld"},  64'(mif.oMEMORY_VALID), 64'(v.exp_v));
      chk({tag, "_lock"}, 64'(mif.oMEMORY_LOCK),  64'(v.exp_l));
      chk({tag, "_dat"},  mif.oMEMORY_DATA,       v.exp_d);
    end
    if (use_mdl) begin
      chk({tag, "_vld"},  64'(mif.oMEMORY_VALID), 64'(mq.size() != 0));
      chk({tag, "_lock"}, 64'(mif.oMEMORY_LOCK),  64'(mq.size() == 4));
      chk({tag, "_dat"},  mif.oMEMORY_DATA,       md);
    end
    lock_b = (mq.size() == 4);
    if (mq.size() != 0 && !v.busy) last_pop = mq.pop_front();
    if (v.srst) begin
      mq.delete();
      last_pop = '0;
    end else if (v.req && !lock_b) begin
      w  = v.addr[11:2];
      wn = w + 10'd1;
      if (v.rw) begin
        for (int i = 0; i < 4; i++)
          if (v.mask[i]) mdl_mem[w][8*i +: 8] = v.wdat[8*i +: 8];
      end else begin
        mq.push_back({mdl_mem[w], mdl_mem[wn]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic req, input logic rw, input logic [31:0] addr,
                              input logic [31:0] wdat, input logic [3:0] mask, input logic busy);
    vec_t v;
    v.req = req; v.rw = rw; v.addr = addr; v.wdat = wdat; v.mask = mask;
    v.busy = busy; v.srst = 1'b0; v.exp_v = 1'b0; v.exp_l = 1'b0; v.exp_d = '0;
    return v;
  endfunction

  localparam logic [63:0] D2  = 64'hDEADBEEF_01234567;
  localparam logic [63:0] D3  = 64'hDEADBEAA_01234567;
  localparam logic [63:0] D5  = 64'h11111111_22222222;
  localparam logic [63:0] R0  = 64'h22222222_A0000001;
  localparam logic [63:0] R4  = 64'hA0000001_A0000002;
  localparam logic [63:0] R8  = 64'hA0000002_A0000003;
  localparam logic [63:0] RC  = 64'hA0000003_DEADBEAA;

  initial begin
    vec_t v;
    logic [31:0] a;

    mif.iMEMORY_REQ = 1'b0; mif.iMEMORY_RW = 1'b0; mif.iMEMORY_ADDR = '0;
    mif.iMEMORY_DATA = '0; mif.iMEMORY_MASK = '0; mif.iMEMORY_ORDER = '0;
    mif.iMEMORY_BUSY = 1'b0;

    // Directed table: each row is one cycle; expectations are the outputs seen during that cycle.
    // Write/write/read, single-cycle response.
    add(1,1,32'h10,  32'hDEADBEEF,4'hF,0,0, 0,0,64'h0);
    add(1,1,32'h14,  32'h01234567,4'hF,0,0, 0,0,64'h0);
    add(1,0,32'h10,  32'h0,       4'h0,0,0, 0,0,64'h0);
    add(0,0,32'h0,   32'h0,       4'h0,0,0, 1,0,D2);
    add(0,0,32'h0,   32'h0,       4'h0,0,0, 0,0,D2);
    // Byte-masked write, then read and aliased read.
    add(1,1,32'h10,  32'h000000AA,4'h1,0,0, 0,0,D2);
    add(1,0,32'h10,  32'h0,       4'h0,0,0, 0,0,D2);
    add(1,0,32'h1010,32'h0,       4'h0,0,0, 1,0,D3);
    add(0,0,32'h0,   32'h0,       4'h0,0,0, 1,0,D3);
    add(0,0,32'h0,   32'h0,       4'h0,0,0, 0,0,D3);
    // Read across the top of the array wraps to word 0.
    add(1,1,32'hFFC, 32'h11111111,4'hF,0,0, 0,0,D3);
    add(1,1,32'h000, 32'h22222222,4'hF,0,0, 0,0,D3);
    add(1,0,32'hFFC, 32'h0,       4'h0,0,0, 0,0,D3);
    add(0,0,32'h0,   32'h0,       4'h0,0,0, 1,0,D5);
    add(0,0,32'h0,   32'h0,       4'h0,0,0, 0,0,D5);
    // Fill under BUSY, fifth read held by LOCK, drained one per cycle.
    add(1,0,32'h0,   32'h0,       4'h0,1,0, 0,0,D5);
    add(1,0,32'h4,   32'h0,       4'h0,1,0, 1,0,R0);
    add(1,0,32'h8,   32'h0,       4'h0,1,0, 1,0,R0);
    add(1,0,32'hC,   32'h0,       4'h0,1,0, 1,0,R0);
    add(1,0,32'h10,  32'h0,       4'h0,1,0, 1,1,R0);
    add(1,0,32'h10,  32'h0,       4'h0,1,0, 1,1,R0);
    add(1,0,32'h10,  32'h0,       4'h0,0,0, 1,1,R0);
    add(1,0,32'h10,  32'h0,       4'h0,0,0, 1,0,R4);
    add(0,0,32'h0,   32'h0,       4'h0,0,0, 1,0,R8);
    add(0,0,32'h0,   32'h0,       4'h0,0,0, 1,0,RC);
    add(0,0,32'h0,   32'h0,       4'h0,0,0, 1,0,D3);
    add(0,0,32'h0,   32'h0,       4'h0,0,0, 0,0,D3);
    // Synchronous flush with two entries queued; array survives.
    add(1,0,32'h0,   32'h0,       4'h0,1,0, 0,0,D3);
    add(1,0,32'h4,   32'h0,       4'h0,1,0, 1,0,R0);
    add(0,0,32'h0,   32'h0,       4'h0,1,1, 1,0,R0);
    add(0,0,32'h0,   32'h0,       4'h0,0,0, 0,0,64'h0);
    add(1,0,32'h10,  32'h0,       4'h0,0,0, 0,0,64'h0);
    add(0,0,32'h0,   32'h0,       4'h0,0,0, 1,0,D3);
    add(0,0,32'h0,   32'h0,       4'h0,0,0, 0,0,D3);

    // Reset state.
    #2;
    chk("rst_vld",  64'(mif.oMEMORY_VALID), 64'h0);
    chk("rst_lock", 64'(mif.oMEMORY_LOCK),  64'h0);
    chk("rst_dat",  mif.oMEMORY_DATA,       64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Preload words 0..16 and 1023 with known values.
    for (int k = 0; k <= 17; k++) begin
      a = (k == 17) ? 32'hFFC : 32'(k * 4);
      step(mk(1, 1, a, 32'hA000_0000 + 32'(a[11:2]), 4'hF, 0), "init", 0, 0);
    end

    // Asynchronous reset mid-cycle with a response pending.
    step(mk(1, 0, 32'h0, 0, 4'h0, 1), "ar_rd", 0, 1);
    mif.iMEMORY_REQ = 1'b0;
    @(negedge clk);
    chk("ar_pre_vld", 64'(mif.oMEMORY_VALID), 64'h1);
    chk("ar_pre_dat", mif.oMEMORY_DATA,       64'hA0000000_A0000001);
    #1 rst = 1'b1;
    #1;
    chk("ar_vld",  64'(mif.oMEMORY_VALID), 64'h0);
    chk("ar_lock", 64'(mif.oMEMORY_LOCK),  64'h0);
    chk("ar_dat",  mif.oMEMORY_DATA,       64'h0);
    #1 rst = 1'b0;
    mq.delete();
    last_pop = '0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i], $sformatf("vec%0d", i), 1, 0);

    // Randomized traffic against the model, addresses confined to preloaded words with aliasing.
    for (int n = 0; n < 400; n++) begin
      a = $urandom();
      a[11:2] = 10'($urandom_range(0, 15));
      v = mk(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), a, $urandom(),
             4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
      step(v, $sformatf("rnd%0d", n), 0, 1);
    end
    for (int n = 0; n < 8; n++)
      step(mk(0, 0, 0, 0, 4'h0, 0), $sformatf("drain%0d", n), 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
